// File: rtl/proj_kmer_seq_ctrl.sv
// K-mer extraction sequencing controller: frames a nucleotide stream into a
// shift-enabled k-mer buffer and emits one qualified k-mer strobe per position.
package proj_pkg;
  localparam int unsigned KMER_BUFFER_BITS = 2;
  localparam int unsigned KMER_BUFFER_LEN  = 4;
endpackage

module proj_kmer_seq_ctrl #(
  parameter int unsigned DATA_BITS = proj_pkg::KMER_BUFFER_BITS,
  parameter int unsigned KMER_LEN  = proj_pkg::KMER_BUFFER_LEN,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_last,
  output logic                 buf_shift_en,
  output logic [DATA_BITS-1:0] buf_data,
  output logic                 buf_start_over,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_pos,
  output logic                 short_read,
  output logic                 read_done,
  output logic [CNT_W-1:0]     read_cnt,
  output logic                 busy
);

  localparam int unsigned FILL_W = $clog2(KMER_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(KMER_LEN);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [FILL_W-1:0]  fill_inc;
  logic               out_valid_d, out_last_d, short_read_d;
  logic [CNT_W-1:0]   pos_d, read_cnt_d;
  logic               accept;

  // Stall the stream whenever a presented k-mer is not being consumed.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, FILL: in_ready = 1'b1;
      STREAM:     in_ready = ~out_last & (~out_valid | out_ready);
      default:    in_ready = 1'b0;
    endcase
  end

  assign accept       = in_valid & in_ready;
  assign buf_shift_en = accept;
  assign buf_data     = in_data;
  assign fill_inc     = fill_q + FILL_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    pos_d        = out_pos;
    read_cnt_d   = read_cnt;
    short_read_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          fill_d = FILL_W'(1);
          if (in_last) begin
            state_d      = CLEAR;
            short_read_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          fill_d = fill_inc;
          if (fill_inc == FILL_FULL) begin
            state_d     = STREAM;
            out_valid_d = 1'b1;
            pos_d       = '0;
            out_last_d  = in_last;
          end else if (in_last) begin
            state_d      = CLEAR;
            short_read_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_last_d  = in_last;
          if (~&out_pos) pos_d = out_pos + CNT_W'(1);
        end else if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last) state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d     = IDLE;
        read_cnt_d  = read_cnt + CNT_W'(1);
        fill_d      = '0;
        pos_d       = '0;
        out_last_d  = 1'b0;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // CLEAR-cycle pulses are registered on entry so they coincide with CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fill_q         <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_pos        <= '0;
      read_cnt       <= '0;
      short_read     <= 1'b0;
      read_done      <= 1'b0;
      buf_start_over <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      out_valid      <= out_valid_d;
      out_last       <= out_last_d;
      out_pos        <= pos_d;
      read_cnt       <= read_cnt_d;
      short_read     <= short_read_d;
      read_done      <= (state_d == CLEAR);
      buf_start_over <= (state_d == CLEAR);
      busy           <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_proj_kmer_seq_ctrl.sv
// Directed bench for proj_kmer_seq_ctrl with a k-mer scoreboard and a narrow
// counter instance that exercises position saturation and read-count wrap.
module tb_proj_kmer_seq_ctrl;

  localparam int unsigned K   = 4;
  localparam int unsigned DW  = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [DW-1:0] in_data;

  logic in_ready, buf_shift_en, buf_start_over, out_valid, out_last;
  logic short_read, read_done, busy;
  logic [DW-1:0] buf_data;
  logic [CW-1:0] out_pos, read_cnt;

  logic in_ready_s, buf_shift_en_s, buf_start_over_s, out_valid_s, out_last_s;
  logic short_read_s, read_done_s, busy_s;
  logic [DW-1:0] buf_data_s;
  logic [CWS-1:0] out_pos_s, read_cnt_s;

  always #5 clk = ~clk;

  proj_kmer_seq_ctrl #(.DATA_BITS(DW), .KMER_LEN(K), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .buf_shift_en(buf_shift_en),
    .buf_data(buf_data), .buf_start_over(buf_start_over), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_pos(out_pos),
    .short_read(short_read), .read_done(read_done), .read_cnt(read_cnt), .busy(busy)
  );

  proj_kmer_seq_ctrl #(.DATA_BITS(DW), .KMER_LEN(K), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .buf_shift_en(buf_shift_en_s),
    .buf_data(buf_data_s), .buf_start_over(buf_start_over_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_last(out_last_s), .out_pos(out_pos_s),
    .short_read(short_read_s), .read_done(read_done_s), .read_cnt(read_cnt_s), .busy(busy_s)
  );

  // External k-mer buffer driven only by the controller's buffer controls.
  logic [K*DW-1:0] tb_buf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tb_buf <= '0;
    else if (buf_start_over) tb_buf <= '0;
    else if (buf_shift_en)   tb_buf <= {tb_buf[(K-1)*DW-1:0], buf_data};
  end

  typedef struct {
    int              pos;
    logic            last;
    logic [K*DW-1:0] kmer;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] nts [64];
  int            n_total   = 0;
  int            n_pass    = 0;
  int            reads_exp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [K*DW-1:0] kmer_of(input int s);
    logic [K*DW-1:0] r = '0;
    for (int j = 0; j < K; j++) r = {r[(K-1)*DW-1:0], nts[s+j]};
    return r;
  endfunction

  // Every consumed k-mer must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_kmer", 64'(out_pos), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        int   sp;
        e  = sbq.pop_front();
        sp = (e.pos > 7) ? 7 : e.pos;
        chk("kmer_pos",   64'(out_pos),   64'(e.pos));
        chk("kmer_last",  64'(out_last),  64'(e.last));
        chk("kmer_data",  64'(tb_buf),    64'(e.kmer));
        chk("kmer_s_pos", 64'({out_valid_s, out_last_s, out_pos_s}),
            64'({1'b1, e.last, CWS'(sp)}));
      end
    end
  end

  // Drive one read; optional stall at a position, optional abort after N accepts.
  task automatic send_read(input int len, input int seed, input int stall_pos,
                           input int stall_n, input int abort_at);
    int   i          = 0;
    int   stall_left = stall_n;
    int   guard      = 0;
    int   lat        = -1;
    logic acc;
    for (int j = 0; j < len; j++) nts[j] = (seed == 0) ? DW'(j) : DW'($urandom);
    while (i < len && i != abort_at) begin
      in_valid = 1'b1;
      in_data  = nts[i];
      in_last  = (i == len - 1);
      if (stall_left > 0 && out_valid && out_pos == CW'(stall_pos)) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (guard == 0) begin
        chk("idle_ready",  64'({in_ready, in_ready_s, busy}), 64'({1'b1, 1'b1, 1'b0}));
        chk("read_cnt",    64'(read_cnt),   64'(reads_exp));
        chk("read_cnt_s",  64'(read_cnt_s), 64'(reads_exp % 8));
      end
      if (!out_ready) begin
        chk("stall_ready", 64'(in_ready), 64'(0));
        chk("stall_pos",   64'(out_pos),  64'(stall_pos));
        chk("stall_buf",   64'(tb_buf),   64'(kmer_of(stall_pos)));
      end
      acc = in_ready;
      if (acc) begin
        chk("shift_s", 64'({buf_shift_en_s, buf_data_s}), 64'({1'b1, nts[i]}));
        if (i >= int'(K) - 1)
          sbq.push_back('{i - int'(K) + 1, logic'(i == len - 1), kmer_of(i - int'(K) + 1)});
        i++;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 64'(i), 64'(len));
        break;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    if (i == abort_at) return;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (read_done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("read_done_seen", 64'(lat >= 0), 64'(1));
    if (lat >= 0) begin
      chk("clear_latency", 64'(lat), 64'((len < int'(K)) ? 0 : 1));
      chk("clear_flags", 64'({short_read, buf_start_over, in_ready, out_valid, busy}),
          64'({logic'(len < int'(K)), 1'b1, 1'b0, 1'b0, 1'b1}));
      chk("clear_flags_s", 64'({short_read_s, buf_start_over_s, read_done_s}),
          64'({logic'(len < int'(K)), 1'b1, 1'b1}));
      chk("sb_drained", 64'(sbq.size()), 64'(0));
      reads_exp++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flags", 64'({out_valid, out_last, short_read, read_done, buf_start_over, busy}), 64'(0));
    chk("rst_counts", 64'({out_pos, read_cnt}), 64'(0));
    chk("rst_buf", 64'(tb_buf), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_read(6, 0, -1, 0, -1);
    send_read(3, 1, -1, 0, -1);
    send_read(10, 1, 2, 3, -1);
    send_read(5, 1, -1, 0, -1);
    send_read(5, 1, -1, 0, -1);
    send_read(2, 1, -1, 0, -1);
    send_read(12, 1, -1, 0, -1);
    send_read(1, 1, -1, 0, -1);
    send_read(4, 1, -1, 0, -1);

    send_read(8, 1, -1, 0, 6);
    chk("pre_rst_stream", 64'({out_valid, busy}), 64'({1'b1, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", 64'({out_valid, out_last, short_read, read_done, buf_start_over, busy}), 64'(0));
    chk("async_rst_counts", 64'({out_pos, read_cnt}), 64'(0));
    sbq.delete();
    reads_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_read(5, 1, -1, 0, -1);
    @(negedge clk);
    chk("final_state", 64'({busy, read_cnt}), 64'({1'b0, CW'(1)}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/proj_kmer_seq_ctrl.md
# proj_kmer_seq_ctrl

Sequencing controller for the k-mer extraction stage. Accepts a per-read nucleotide stream with valid/ready/last framing and drives a shift-enabled k-mer shift buffer (shift enable, data, start_over). It tracks fill depth itself and emits one ready/valid-qualified k-mer strobe per buffer position once K nucleotides are loaded, clearing the buffer between reads. It sits between the read-stream front end and the MinHash hash units.

## Interface
- DATA_BITS, proj_pkg::KMER_BUFFER_BITS, bits per nucleotide
- KMER_LEN, proj_pkg::KMER_BUFFER_LEN, k (must be >= 2)
- CNT_W, 16, width of position and read counters

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  nucleotide valid
- in_ready  out  1  controller accepts nucleotide
- in_data  in  DATA_BITS  nucleotide
- in_last  in  1  last nucleotide of read
- buf_shift_en  out  1  buffer shifts in buf_data this edge
- buf_data  out  DATA_BITS  in_data pass-through
- buf_start_over  out  1  clear buffer this edge
- out_valid  out  1  buffer holds a valid k-mer
- out_ready  in  1  downstream consumes k-mer
- out_last  out  1  k-mer is last of its read
- out_pos  out  CNT_W  0-based start index of k-mer in read
- short_read  out  1  one-cycle pulse: read ended with < KMER_LEN nucleotides
- read_done  out  1  one-cycle pulse in CLEAR
- read_cnt  out  CNT_W  completed reads, wraps
- busy  out  1  state != IDLE

## Operation
- Accept = in_valid & in_ready; buf_shift_en = accept (combinational); buf_data = in_data.
- fill_cnt (clog2(KMER_LEN+1) bits) counts nucleotides accepted in current read, saturates at KMER_LEN.
- States: IDLE, FILL, STREAM, CLEAR.
- IDLE: in_ready=1. Accept -> FILL, fill_cnt=1; if in_last also -> CLEAR with short_read.
- FILL: in_ready=1. Accept increments fill_cnt; reaching KMER_LEN -> STREAM, out_valid=1, out_pos=0, out_last=in_last. in_last with fill_cnt+1 < KMER_LEN -> CLEAR, short_read pulse.
- STREAM: in_ready = ~out_last & (~out_valid | out_ready). Accept sets out_valid=1, out_pos+1 (saturate at all-ones), out_last=in_last. Handshake without accept clears out_valid. Handshake while out_last=1 -> CLEAR.
- CLEAR: one cycle; in_ready=0, buf_start_over=1, read_done=1, read_cnt+1 (wrap), fill_cnt/out_pos/out_last cleared -> IDLE.
- out_valid, out_last, out_pos stable while out_valid & ~out_ready.

## Timing
- Reset: state=IDLE; out_valid, out_last, short_read, read_done, buf_start_over=0; out_pos, read_cnt, fill_cnt=0; in_ready=1 after reset release.
- Buffer is registered: k-mer containing nucleotide accepted at edge t is valid in buffer at t+1, coinciding with out_valid.
- Latency: first out_valid one cycle after the KMER_LEN-th accept; steady state one k-mer per cycle with in_valid & out_ready high.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0 (no shift, buffer frozen).
- short_read pulse is registered, asserted in the CLEAR cycle.
- Read gap: exactly one CLEAR cycle between reads; in_ready=0 there.
- rst_n assertion mid-read: immediate return to reset values; no read_done.

## Test plan
- K=4, read ACGTAC (6 nt, last on 6th), out_ready=1 -> 3 k-mers, out_pos 0,1,2, out_last on pos 2, read_done next cycle, read_cnt=1.
- K=4, read of 3 nt -> no out_valid, short_read and read_done in CLEAR cycle, buf_start_over=1.
- K=4, 10 nt, out_ready low 3 cycles at pos 2 -> in_ready=0, out_pos=2 and buffer held, then pos 3..6 consecutive.
- Two back-to-back 5-nt reads -> second read's first accept in cycle after CLEAR, its out_pos restarts at 0, read_cnt=2.
- rst_n pulsed low mid-STREAM -> outputs zero asynchronously, next read processed from pos 0.
- read_cnt preloaded to 0xFFFF via 65535 short reads (or forced) -> wraps to 0.
